// File: rtl/decode_queue.sv
// RV32I decode queue: DEPTH-entry fetch FIFO whose head is decoded into a
// registered issue slot handed to the ROB/RS over a valid/ready handshake.
module decode_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_instr,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             fetch_ready,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [6:0]       op_type,
  output logic [2:0]       op_subtype,
  output logic             op_flag,
  output logic [XLEN-1:0]  imm,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             uses_rs1,
  output logic             uses_rs2,
  output logic             writes_rd,
  output logic             illegal,
  output logic [31:0]      instr_out,
  output logic [XLEN-1:0]  pc_out,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL      = (PTR_W+1)'(DEPTH);
  localparam logic [6:0]     OPC_LUI   = 7'b0110111;
  localparam logic [6:0]     OPC_AUIPC = 7'b0010111;
  localparam logic [6:0]     OPC_JAL   = 7'b1101111;
  localparam logic [6:0]     OPC_JALR  = 7'b1100111;
  localparam logic [6:0]     OPC_BR    = 7'b1100011;
  localparam logic [6:0]     OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]     OPC_STORE = 7'b0100011;
  localparam logic [6:0]     OPC_OPIMM = 7'b0010011;
  localparam logic [6:0]     OPC_OP    = 7'b0110011;
  localparam logic [6:0]     OPC_FENCE = 7'b0001111;

  logic [31:0]      q_instr [DEPTH];
  logic [XLEN-1:0]  q_pc    [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [31:0]      h_instr;

  logic [6:0]       d_type;
  logic [2:0]       d_sub;
  logic             d_flag;
  logic [31:0]      d_imm32;
  logic [4:0]       d_rs1;
  logic [4:0]       d_rs2;
  logic [4:0]       d_rd;
  logic             d_u1;
  logic             d_u2;
  logic             d_w;
  logic             d_ill;

  // Readiness is independent of a same-cycle pop, so a full queue stalls fetch.
  assign fetch_ready = !reset && (count != FULL);
  assign push        = fetch_valid && fetch_ready;
  assign pop         = (count != '0) && (!issue_valid || issue_ready);
  assign h_instr     = q_instr[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset && !flush && push) begin
      q_instr[wr_ptr] <= fetch_instr;
      q_pc[wr_ptr]    <= fetch_pc;
    end
  end

  // Head decode; immediates are built at 32 bits then sign-extended to XLEN.
  always_comb begin
    d_type  = h_instr[6:0];
    d_sub   = h_instr[14:12];
    d_flag  = 1'b0;
    d_imm32 = '0;
    d_rs1   = '0;
    d_rs2   = '0;
    d_rd    = '0;
    d_u1    = 1'b0;
    d_u2    = 1'b0;
    d_w     = 1'b0;
    d_ill   = 1'b0;
    case (h_instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        d_sub   = 3'b111;
        d_imm32 = {h_instr[31:12], 12'b0};
        d_rd    = h_instr[11:7];
        d_w     = 1'b1;
      end
      OPC_JAL: begin
        d_sub   = 3'b111;
        d_imm32 = {{11{h_instr[31]}}, h_instr[31], h_instr[19:12], h_instr[20],
                   h_instr[30:21], 1'b0};
        d_rd    = h_instr[11:7];
        d_w     = 1'b1;
      end
      OPC_JALR, OPC_LOAD: begin
        d_imm32 = {{20{h_instr[31]}}, h_instr[31:20]};
        d_rs1   = h_instr[19:15];
        d_u1    = 1'b1;
        d_rd    = h_instr[11:7];
        d_w     = 1'b1;
      end
      OPC_BR: begin
        d_imm32 = {{19{h_instr[31]}}, h_instr[31], h_instr[7], h_instr[30:25],
                   h_instr[11:8], 1'b0};
        d_rs1   = h_instr[19:15];
        d_rs2   = h_instr[24:20];
        d_u1    = 1'b1;
        d_u2    = 1'b1;
      end
      OPC_STORE: begin
        d_imm32 = {{20{h_instr[31]}}, h_instr[31:25], h_instr[11:7]};
        d_rs1   = h_instr[19:15];
        d_rs2   = h_instr[24:20];
        d_u1    = 1'b1;
        d_u2    = 1'b1;
      end
      OPC_OPIMM: begin
        if (h_instr[13:12] == 2'b01) begin
          d_imm32 = {27'b0, h_instr[24:20]};
          d_flag  = h_instr[30];
        end else begin
          d_imm32 = {{20{h_instr[31]}}, h_instr[31:20]};
        end
        d_rs1 = h_instr[19:15];
        d_u1  = 1'b1;
        d_rd  = h_instr[11:7];
        d_w   = 1'b1;
      end
      OPC_OP: begin
        d_flag = h_instr[30];
        d_rs1  = h_instr[19:15];
        d_rs2  = h_instr[24:20];
        d_u1   = 1'b1;
        d_u2   = 1'b1;
        d_rd   = h_instr[11:7];
        d_w    = 1'b1;
      end
      OPC_FENCE: d_imm32 = {24'b0, h_instr[27:20]};
      default: begin
        d_sub = 3'b111;
        d_ill = 1'b1;
      end
    endcase
    if (d_rd == 5'd0) d_w = 1'b0;
  end

  // Pointers, occupancy and issue slot; decoded fields hold when the slot empties.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      issue_valid <= 1'b0;
      op_type     <= '0;
      op_subtype  <= '0;
      op_flag     <= 1'b0;
      imm         <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      uses_rs1    <= 1'b0;
      uses_rs2    <= 1'b0;
      writes_rd   <= 1'b0;
      illegal     <= 1'b0;
      instr_out   <= '0;
      pc_out      <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      issue_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        issue_valid <= 1'b1;
        op_type     <= d_type;
        op_subtype  <= d_sub;
        op_flag     <= d_flag;
        imm         <= XLEN'($signed(d_imm32));
        rs1         <= d_rs1;
        rs2         <= d_rs2;
        rd          <= d_rd;
        uses_rs1    <= d_u1;
        uses_rs2    <= d_u2;
        writes_rd   <= d_w;
        illegal     <= d_ill;
        instr_out   <= h_instr;
        pc_out      <= q_pc[rd_ptr];
      end else if (issue_valid && issue_ready) begin
        issue_valid <= 1'b0;
      end
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Randomised self-checking bench for decode_queue against a queue-based
// reference model that decodes from the RV32I field rules.
module tb_decode_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [6:0]  op_type;
    logic [2:0]  sub;
    logic        flag;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic        w;
    logic        ill;
    logic [31:0] instr;
    logic [31:0] pc;
  } dec_t;

  typedef struct packed {
    logic       valid;
    logic       ready;
    logic [2:0] count;
    dec_t       dec;
  } obs_t;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        issue_valid;
  logic        issue_ready;
  logic [6:0]  op_type;
  logic [2:0]  op_subtype;
  logic        op_flag;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        writes_rd;
  logic        illegal;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] q[$];
  logic        m_valid = 1'b0;
  logic        m_rst = 1'b1;
  dec_t        m_dec = '0;

  decode_queue #(.XLEN(32), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op_type(op_type), .op_subtype(op_subtype), .op_flag(op_flag), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .writes_rd(writes_rd), .illegal(illegal), .instr_out(instr_out),
    .pc_out(pc_out), .count(count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference decode from the ISA field layout, using shifts and masks.
  function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    dec_t d;
    logic signed [31:0] si;
    logic [31:0] a11, a19, a20;
    si  = ins;
    a11 = si >>> 11;
    a19 = si >>> 19;
    a20 = si >>> 20;
    d = '0;
    d.op_type = ins[6:0];
    d.sub = ins[14:12];
    d.instr = ins;
    d.pc = pc;
    case (ins[6:0])
      7'h37, 7'h17: begin d.sub = 3'd7; d.imm = ins & 32'hFFFFF000; d.rd = ins[11:7]; d.w = 1; end
      7'h6F: begin
        d.sub = 3'd7;
        d.imm = (a11 & 32'hFFF00000) | (ins & 32'h000FF000) | ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
        d.rd = ins[11:7]; d.w = 1;
      end
      7'h67, 7'h03: begin d.imm = a20; d.rs1 = ins[19:15]; d.u1 = 1; d.rd = ins[11:7]; d.w = 1; end
      7'h63: begin
        d.imm = (a19 & 32'hFFFFF000) | ((ins << 4) & 32'h800) | ((ins >> 20) & 32'h7E0) | ((ins >> 7) & 32'h1E);
        d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.u1 = 1; d.u2 = 1;
      end
      7'h23: begin
        d.imm = (a20 & ~32'h1F) | ((ins >> 7) & 32'h1F);
        d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.u1 = 1; d.u2 = 1;
      end
      7'h13: begin
        if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) begin
          d.imm = (ins >> 20) & 32'h1F; d.flag = ins[30];
        end else d.imm = a20;
        d.rs1 = ins[19:15]; d.u1 = 1; d.rd = ins[11:7]; d.w = 1;
      end
      7'h33: begin
        d.flag = ins[30]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.u1 = 1; d.u2 = 1;
        d.rd = ins[11:7]; d.w = 1;
      end
      7'h0F: d.imm = (ins >> 20) & 32'hFF;
      default: begin d.sub = 3'd7; d.ill = 1; end
    endcase
    if (d.rd == 5'd0) d.w = 0;
    return d;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.valid = issue_valid; o.ready = fetch_ready; o.count = count;
    o.dec.op_type = op_type; o.dec.sub = op_subtype; o.dec.flag = op_flag; o.dec.imm = imm;
    o.dec.rs1 = rs1; o.dec.rs2 = rs2; o.dec.rd = rd; o.dec.u1 = uses_rs1; o.dec.u2 = uses_rs2;
    o.dec.w = writes_rd; o.dec.ill = illegal; o.dec.instr = instr_out; o.dec.pc = pc_out;
    return o;
  endfunction

  function automatic obs_t exp_obs();
    obs_t o;
    o.valid = m_valid;
    o.ready = !m_rst && (q.size() != DEPTH);
    o.count = 3'(q.size());
    o.dec = m_dec;
    return o;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h7F};
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], opcs[$urandom_range(0, 10)]};
  endfunction

  task automatic model_update(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                              input logic rdy, input logic fl, input logic rst);
    logic acc, pp;
    logic [63:0] e;
    m_rst = rst;
    if (rst) begin
      q.delete(); m_valid = 0; m_dec = '0;
    end else if (fl) begin
      q.delete(); m_valid = 0;
    end else begin
      acc = v && (q.size() != DEPTH);
      pp  = (q.size() != 0) && (!m_valid || rdy);
      if (pp) begin
        e = q.pop_front();
        m_dec = ref_decode(e[63:32], e[31:0]);
        m_valid = 1;
      end else if (m_valid && rdy) m_valid = 0;
      if (acc) q.push_back({ins, pc});
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl, input logic rst);
    fetch_valid = v; fetch_instr = ins; fetch_pc = pc;
    issue_ready = rdy; flush = fl; reset = rst;
    @(posedge clock);
    model_update(v, ins, pc, rdy, fl, rst);
    #1;
  endtask

  task automatic test_reset();
    obs_t o;
    step(1'b1, 32'h13, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    o = dut_obs();
    vectors++;
    if (o !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", o, obs_t'('0));
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (fetch_ready !== 1'b1 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b count=%0d want ready=1 count=0", fetch_ready, count);
    end
  endtask

  task automatic test_basic();
    step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (issue_valid !== 1'b0 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL basic_latency: valid=%b count=%0d want 0/1", issue_valid, count);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (issue_valid !== 1'b1 || op_type !== 7'b0010011 || op_subtype !== 3'b000 || rd !== 5'd1 ||
        writes_rd !== 1'b1 || uses_rs1 !== 1'b1 || uses_rs2 !== 1'b0 || imm !== 32'd5 ||
        pc_out !== 32'h100 || illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_addi: v=%b type=%b sub=%b rd=%0d w=%b u1=%b imm=%h pc=%h",
               issue_valid, op_type, op_subtype, rd, writes_rd, uses_rs1, imm, pc_out);
    end
    vectors++;
    if (dut_obs() !== exp_obs()) begin
      miscompares++;
      $display("FAIL basic_model: got %h want %h", dut_obs(), exp_obs());
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (issue_valid !== 1'b0 || imm !== 32'd5) begin
      miscompares++;
      $display("FAIL basic_clear: valid=%b imm=%h want 0 and held 5", issue_valid, imm);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pushed [DEPTH+1];
    logic [31:0] issued [$];
    for (int i = 0; i <= DEPTH; i++) begin
      pushed[i] = rand_instr();
      step(1'b1, pushed[i], 32'h200 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
      vectors++;
      if (dut_obs() !== exp_obs()) begin
        miscompares++;
        $display("FAIL bp_fill[%0d]: got %h want %h", i, dut_obs(), exp_obs());
      end
    end
    vectors++;
    if (count !== 3'(DEPTH) || fetch_ready !== 1'b0 || issue_valid !== 1'b1 || instr_out !== pushed[0]) begin
      miscompares++;
      $display("FAIL bp_full: count=%0d ready=%b valid=%b instr=%h want %0d 0 1 %h",
               count, fetch_ready, issue_valid, instr_out, DEPTH, pushed[0]);
    end
    for (int i = 0; i < 10; i++) begin
      if (issue_valid) issued.push_back(instr_out);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (dut_obs() !== exp_obs()) begin
        miscompares++;
        $display("FAIL bp_drain[%0d]: got %h want %h", i, dut_obs(), exp_obs());
      end
    end
    vectors++;
    if (issued.size() != DEPTH + 1) begin
      miscompares++;
      $display("FAIL bp_issue_count: got %0d want %0d", issued.size(), DEPTH + 1);
    end else begin
      for (int i = 0; i <= DEPTH; i++) begin
        vectors++;
        if (issued[i] !== pushed[i]) begin
          miscompares++;
          $display("FAIL bp_order[%0d]: got %h want %h", i, issued[i], pushed[i]);
        end
      end
    end
  endtask

  task automatic test_immediates();
    logic [31:0] ins [5]  = '{32'hFE000EE3, 32'h4030D093, 32'h800000EF, 32'h00000013, 32'h0000007F};
    logic [31:0] eimm [5] = '{32'hFFFFFFFC, 32'd3, 32'hFFF00000, 32'd0, 32'd0};
    logic [4:0]  eflg [5] = '{5'b11000, 5'b10110, 5'b00100, 5'b10000, 5'b00001};
    logic [4:0]  got;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ins[i], 32'h400 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      got = {uses_rs1, uses_rs2, writes_rd, op_flag, illegal};
      vectors++;
      if (issue_valid !== 1'b1 || imm !== eimm[i] || got !== eflg[i]) begin
        miscompares++;
        $display("FAIL imm_case[%0d]: valid=%b imm=%h flags=%b want 1 %h %b",
                 i, issue_valid, imm, got, eimm[i], eflg[i]);
      end
      vectors++;
      if (dut_obs() !== exp_obs()) begin
        miscompares++;
        $display("FAIL imm_model[%0d]: got %h want %h", i, dut_obs(), exp_obs());
      end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    vectors++;
    if (op_subtype !== 3'b111 || op_type !== 7'h7F || rd !== 5'd0) begin
      miscompares++;
      $display("FAIL illegal_fields: sub=%b type=%h rd=%0d want 111 7f 0", op_subtype, op_type, rd);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) step(1'b1, rand_instr(), 32'h500 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    vectors++;
    if (count !== 3'd3 || issue_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_setup: count=%0d valid=%b want 3 1", count, issue_valid);
    end
    step(1'b1, 32'h00A00513, 32'h5F0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (count !== 3'd0 || issue_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_clear: count=%0d valid=%b ready=%b want 0 0 1", count, issue_valid, fetch_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (issue_valid !== 1'b0 || dut_obs() !== exp_obs()) begin
        miscompares++;
        $display("FAIL flush_drop[%0d]: got %h want %h", i, dut_obs(), exp_obs());
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, rand_instr(), 32'h1000 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
      vectors++;
      if (count > 3'd1 || (i > 0 && issue_valid !== 1'b1) || dut_obs() !== exp_obs()) begin
        miscompares++;
        $display("FAIL stream[%0d]: got %h want %h", i, dut_obs(), exp_obs());
      end
    end
    step(1'b1, rand_instr(), 32'h2000, 1'b1, 1'b0, 1'b1);
    o = dut_obs();
    vectors++;
    if (o !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL stream_reset: got %h want %h", o, obs_t'('0));
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (fetch_ready !== 1'b1 || issue_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_after_reset: ready=%b valid=%b want 1 0", fetch_ready, issue_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), rand_instr(), $urandom(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0), 1'b0);
      vectors++;
      if (dut_obs() !== exp_obs()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_obs(), exp_obs());
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_instr = '0;
    fetch_pc = '0; issue_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_immediates();
    test_flush();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
